// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, control-field
// codes, FSM state encoding and the packed control word.
package multicycle_control_pkg;

    localparam int STATE_W = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Also consumed by the immediate generator.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_RS1 = 1'b1;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] imm_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_control_outputs.sv
// Combinational state-to-control-word decoder. Only FETCH looks at mem_ready
// (IR/PC load on the completing read) and only MEM_ADDR looks at the load/store flag.
module control_outputs
    import multicycle_control_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   is_load,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_sel   = IMM_B;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_sel   = IMM_I;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_sel   = is_load ? IMM_I : IMM_S;
            end
            S_MEM_RD: ctrl.mem_read = 1'b1;
            S_MEM_WR: ctrl.mem_write = 1'b1;
            S_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WBSEL_ALU;
            end
            S_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WBSEL_MEM;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_RS1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.alu_op        = ALU_CMP;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JAL: begin
                ctrl.imm_sel   = IMM_J;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.pc_write  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WBSEL_PC4;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV32I datapath; the state register and
// next-state logic live here, the control word comes from control_outputs.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction, PC+4; IR/PC load on mem_ready
// DECODE   | read regs, precompute branch target, dispatch
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// MEM_ADDR | effective address for load/store
// MEM_RD   | load data read, waits on mem_ready
// MEM_WR   | store data write, waits on mem_ready
// WB_ALU   | write ALU result to rd
// WB_MEM   | write load data to rd
// BRANCH   | compare, conditional PC load
// JAL      | PC <- target, rd <- PC+4
// HALT     | illegal opcode, sticky until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int RESET_STATE_W = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    input  logic                     mem_ready,
    input  logic                     branch_taken,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic [2:0]               imm_sel,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     reg_write,
    output logic [1:0]               wb_sel,
    output logic                     halted,
    output logic [RESET_STATE_W-1:0] state
);

    state_t state_q;
    ctrl_t  ctrl;
    logic   is_load;

    // The IR holds the opcode stable from DECODE until the next FETCH completes.
    assign is_load = (opcode == OP_LD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_q <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_R:         state_q <= S_EXEC_R;
                        OP_I:         state_q <= S_EXEC_I;
                        OP_LD, OP_ST: state_q <= S_MEM_ADDR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_JAL:       state_q <= S_JAL;
                        default:      state_q <= S_HALT;
                    endcase
                end
                S_EXEC_R:   state_q <= S_WB_ALU;
                S_EXEC_I:   state_q <= S_WB_ALU;
                S_MEM_ADDR: state_q <= is_load ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_q <= mem_ready ? S_WB_MEM : S_MEM_RD;
                S_MEM_WR:   state_q <= mem_ready ? S_FETCH : S_MEM_WR;
                S_WB_ALU:   state_q <= S_FETCH;
                S_WB_MEM:   state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_JAL:      state_q <= S_FETCH;
                S_HALT:     state_q <= S_HALT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    control_outputs u_control_outputs (
        .state     (state_q),
        .mem_ready (mem_ready),
        .is_load   (is_load),
        .ctrl      (ctrl)
    );

    // branch_taken gates the PC in the datapath; the sequence itself never depends on it.
    logic unused_branch_taken;
    assign unused_branch_taken = branch_taken;

    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign imm_sel       = ctrl.imm_sel;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign wb_sel        = ctrl.wb_sel;
    assign halted        = ctrl.halted;
    assign state         = RESET_STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into a per-cycle
// trace of expected state and control word, then replayed against the DUT.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       ir_write, pc_write, pc_write_cond, alu_src_a;
    logic       mem_read, mem_write, reg_write, halted;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_b, alu_op, wb_sel;
    logic [3:0] state;

    multicycle_control #(.RESET_STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .imm_sel       (imm_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .halted        (halted),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] imm_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       halted;
    } exp_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       bt;
        logic [6:0] op;
        exp_t       e;
    } step_t;

    step_t       trace[$];
    int          checks = 0;
    int          errors = 0;
    logic [16:0] obs_v;

    assign obs_v = {ir_write, pc_write, pc_write_cond, imm_sel, alu_src_a, alu_src_b,
                    alu_op, mem_read, mem_write, reg_write, wb_sel, halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST
            || op == OP_BEQ || op == OP_JAL;
    endfunction

    task automatic add(input logic [3:0] s, input logic mr, input logic bt,
                       input logic [6:0] op, input exp_t e);
        step_t t;
        t.st = s; t.mr = mr; t.bt = bt; t.op = op; t.e = e;
        trace.push_back(t);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction: fw fetch wait
    // cycles, mw data-memory wait cycles, bt the branch outcome.
    task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1; e.alu_src_b = 2;
            add(S_FETCH, 1'b0, rb(), rop(), e);
        end
        e = '0; e.mem_read = 1; e.alu_src_b = 2; e.ir_write = 1; e.pc_write = 1;
        add(S_FETCH, 1'b1, rb(), rop(), e);
        e = '0; e.alu_src_b = 1; e.imm_sel = 2;
        add(S_DECODE, rb(), rb(), op, e);
        case (op)
            OP_R, OP_I: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 2;
                e.alu_src_b = (op == OP_I) ? 2'd1 : 2'd0;
                add((op == OP_I) ? S_EXEC_I : S_EXEC_R, rb(), rb(), op, e);
                e = '0; e.reg_write = 1;
                add(S_WB_ALU, rb(), rb(), op, e);
            end
            OP_LD, OP_ST: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 1;
                e.imm_sel = (op == OP_ST) ? 3'd1 : 3'd0;
                add(S_MEM_ADDR, rb(), rb(), op, e);
                e = '0;
                if (op == OP_LD) e.mem_read = 1; else e.mem_write = 1;
                for (int i = 0; i <= mw; i++)
                    add((op == OP_LD) ? S_MEM_RD : S_MEM_WR, (i == mw), rb(), op, e);
                if (op == OP_LD) begin
                    e = '0; e.reg_write = 1; e.wb_sel = 1;
                    add(S_WB_MEM, rb(), rb(), op, e);
                end
            end
            OP_BEQ: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 1; e.pc_write_cond = 1;
                add(S_BRANCH, rb(), bt, op, e);
            end
            OP_JAL: begin
                e = '0; e.imm_sel = 3; e.alu_src_b = 1; e.pc_write = 1;
                e.reg_write = 1; e.wb_sel = 2;
                add(S_JAL, rb(), rb(), op, e);
            end
            default: begin
                e = '0; e.halted = 1;
                for (int i = 0; i < 8; i++) add(S_HALT, rb(), rb(), rop(), e);
            end
        endcase
    endtask

    task automatic run(input int n);
        step_t t;
        int    k = 0;
        while (trace.size() > 0 && (n < 0 || k < n)) begin
            t = trace.pop_front();
            @(negedge clk);
            opcode = t.op; mem_ready = t.mr; branch_taken = t.bt;
            #1;
            check("state", state, t.st);
            check("ctrl_word", obs_v, t.e);
            check("rd_wr_exclusive", mem_read & mem_write, 0);
            check("pc_wr_exclusive", pc_write & pc_write_cond, 0);
            k++;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_state", state, S_FETCH);
        check("rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] legal_ops [6];
        logic [6:0] op;
        legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BEQ, OP_JAL};

        rst = 1'b1; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0;
        #12;
        check("reset_state", state, S_FETCH);
        check("reset_ctrl", obs_v, 17'h00000 | (17'd1 << 5) | (17'd2 << 8));
        @(negedge clk);
        rst = 1'b0;

        // Async reset in the middle of a load data wait.
        gen_instr(OP_LD, 0, 3, 1'b0);
        run(4);
        trace.delete();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", state, S_FETCH);
        check("async_rst_mem_read", mem_read, 1);
        check("async_rst_reg_write", reg_write, 0);
        check("async_rst_halted", halted, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;

        gen_instr(OP_R, 0, 0, 1'b0);
        gen_instr(OP_LD, 0, 2, 1'b0);
        gen_instr(OP_ST, 1, 1, 1'b0);
        gen_instr(OP_BEQ, 0, 0, 1'b0);
        gen_instr(OP_BEQ, 0, 0, 1'b1);
        gen_instr(OP_I, 2, 0, 1'b0);
        gen_instr(OP_JAL, 0, 0, 1'b0);
        gen_instr(7'b1111111, 0, 0, 1'b0);
        run(-1);
        reset_pulse();

        for (int i = 0; i < 150; i++) begin
            gen_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), rb());
            run(-1);
        end

        op = rop();
        while (is_legal(op)) op = rop();
        gen_instr(op, $urandom_range(0, 2), 0, 1'b0);
        run(-1);
        reset_pulse();
        gen_instr(OP_R, 0, 0, 1'b0);
        run(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
